// File: rtl/sd_cmd_responder.sv
// Card-side command endpoint: accepts a 38-bit command over a four-phase
// strobe/ack handshake, decodes the index and returns a response after a fixed latency.
module sd_cmd_responder #(
  parameter int RESP_DELAY = 4,
  parameter int MAX_INDEX  = 55
) (
  input  logic        iClock_host,
  input  logic        iReset,
  input  logic        iStrobe_in,
  input  logic [37:0] iCmd_in,
  output logic        oAck_out,
  output logic        oStrobe_out,
  output logic [37:0] oResponse,
  input  logic        iAck_in,
  input  logic [31:0] iCard_status,
  output logic        oIdle_out,
  output logic        oIllegal_cmd,
  output logic [5:0]  oCmd_index,
  output logic [31:0] oCmd_argument
);

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] argument;
  } cmdWord_t;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] status;
  } respWord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK_WAIT,
    ST_DECODE,
    ST_WAIT,
    ST_SEND,
    ST_RELEASE
  } state_t;

  localparam logic [7:0] RespDelay = 8'(RESP_DELAY);
  localparam logic [6:0] MaxIndex  = 7'(MAX_INDEX);
  localparam int         IllegalBit = 22;

  state_t      state, stateNext;
  logic        ack, ackNext;
  logic        strobe, strobeNext;
  respWord_t   response, responseNext;
  logic        idle, idleNext;
  logic        illegal, illegalNext;
  logic [5:0]  cmdIndex, cmdIndexNext;
  logic [31:0] cmdArgument, cmdArgumentNext;
  logic [7:0]  counter, counterNext;
  logic        stickyIllegal, stickyIllegalNext;

  cmdWord_t    cmdIn;
  logic [31:0] statusOut;

  assign cmdIn = cmdWord_t'(iCmd_in);

  // The illegal-command flag is folded into the status word exactly once,
  // on the response that follows the illegal command.
  always_comb begin
    statusOut             = iCard_status;
    statusOut[IllegalBit] = iCard_status[IllegalBit] | stickyIllegal;
  end

  always_ff @(posedge iClock_host or negedge iReset) begin
    if (!iReset) begin
      state         <= ST_IDLE;
      ack           <= 1'b0;
      strobe        <= 1'b0;
      response      <= '0;
      idle          <= 1'b1;
      illegal       <= 1'b0;
      cmdIndex      <= '0;
      cmdArgument   <= '0;
      counter       <= '0;
      stickyIllegal <= 1'b0;
    end else begin
      state         <= stateNext;
      ack           <= ackNext;
      strobe        <= strobeNext;
      response      <= responseNext;
      idle          <= idleNext;
      illegal       <= illegalNext;
      cmdIndex      <= cmdIndexNext;
      cmdArgument   <= cmdArgumentNext;
      counter       <= counterNext;
      stickyIllegal <= stickyIllegalNext;
    end
  end

  always_comb begin
    stateNext         = state;
    ackNext           = ack;
    strobeNext        = strobe;
    responseNext      = response;
    idleNext          = idle;
    illegalNext       = 1'b0;
    cmdIndexNext      = cmdIndex;
    cmdArgumentNext   = cmdArgument;
    counterNext       = counter;
    stickyIllegalNext = stickyIllegal;

    unique case (state)
      ST_IDLE: begin
        if (iStrobe_in) begin
          cmdIndexNext    = cmdIn.index;
          cmdArgumentNext = cmdIn.argument;
          ackNext         = 1'b1;
          idleNext        = 1'b0;
          stateNext       = ST_ACK_WAIT;
        end
      end
      ST_ACK_WAIT: begin
        if (!iStrobe_in) begin
          ackNext   = 1'b0;
          stateNext = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if ({1'b0, cmdIndex} > MaxIndex) begin
          illegalNext       = 1'b1;
          stickyIllegalNext = 1'b1;
          idleNext          = 1'b1;
          stateNext         = ST_IDLE;
        end else if (cmdIndex == 6'd0) begin
          // GO_IDLE: no response, and it clears any pending illegal flag
          stickyIllegalNext = 1'b0;
          idleNext          = 1'b1;
          stateNext         = ST_IDLE;
        end else begin
          counterNext = RespDelay;
          stateNext   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (counter != 8'd0) begin
          counterNext = counter - 8'd1;
        end else begin
          responseNext.index  = cmdIndex;
          responseNext.status = statusOut;
          strobeNext          = 1'b1;
          stickyIllegalNext   = 1'b0;
          stateNext           = ST_SEND;
        end
      end
      ST_SEND: begin
        if (iAck_in) begin
          strobeNext = 1'b0;
          stateNext  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!iAck_in) begin
          idleNext  = 1'b1;
          stateNext = ST_IDLE;
        end
      end
      default: begin
        stateNext = ST_IDLE;
        idleNext  = 1'b1;
      end
    endcase
  end

  assign oAck_out      = ack;
  assign oStrobe_out   = strobe;
  assign oResponse     = response;
  assign oIdle_out     = idle;
  assign oIllegal_cmd  = illegal;
  assign oCmd_index    = cmdIndex;
  assign oCmd_argument = cmdArgument;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: handshakes, latency, illegal/GO_IDLE
// handling, response hold and mid-transaction reset.
module tb_sd_cmd_responder;

  logic        clk = 1'b0;
  logic        rstN;
  logic        iStrobe_in;
  logic [37:0] iCmd_in;
  logic        oAck_out;
  logic        oStrobe_out;
  logic [37:0] oResponse;
  logic        iAck_in;
  logic [31:0] iCard_status;
  logic        oIdle_out;
  logic        oIllegal_cmd;
  logic [5:0]  oCmd_index;
  logic [31:0] oCmd_argument;

  int errors = 0;
  int checks = 0;

  sd_cmd_responder #(.RESP_DELAY(4), .MAX_INDEX(55)) dut (
    .iClock_host  (clk),
    .iReset       (rstN),
    .iStrobe_in   (iStrobe_in),
    .iCmd_in      (iCmd_in),
    .oAck_out     (oAck_out),
    .oStrobe_out  (oStrobe_out),
    .oResponse    (oResponse),
    .iAck_in      (iAck_in),
    .iCard_status (iCard_status),
    .oIdle_out    (oIdle_out),
    .oIllegal_cmd (oIllegal_cmd),
    .oCmd_index   (oCmd_index),
    .oCmd_argument(oCmd_argument)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full command handshake; returns at the first negedge where ack is seen low.
  task automatic sendCmd(input logic [5:0] idx, input logic [31:0] arg);
    int n;
    @(negedge clk);
    iStrobe_in = 1'b1;
    iCmd_in    = {idx, arg};
    n = 0;
    do begin @(negedge clk); n++; end while (!oAck_out && n < 20);
    chk("cmd_ack_rise", 64'(oAck_out), 64'd1);
    iStrobe_in = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (oAck_out && n < 20);
    chk("cmd_ack_fall", 64'(oAck_out), 64'd0);
  endtask

  task automatic waitStrobe(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!oStrobe_out && n < 40);
  endtask

  task automatic finishResp();
    int n;
    iAck_in = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (oStrobe_out && n < 20);
    chk("resp_strobe_fall", 64'(oStrobe_out), 64'd0);
    iAck_in = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!oIdle_out && n < 20);
    chk("resp_idle_return", 64'(oIdle_out), 64'd1);
  endtask

  // Watches a window after a no-response command.
  task automatic watchNoResp(input int cycles, output int illegalHigh, output int strobeHigh,
                             output int idleAt);
    illegalHigh = 0; strobeHigh = 0; idleAt = -1;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (oIllegal_cmd) illegalHigh++;
      if (oStrobe_out) strobeHigh++;
      if (oIdle_out && idleAt < 0) idleAt = i;
    end
  endtask

  initial begin
    int lat, ill, stb, idleAt, bad;

    rstN = 1'b0; iStrobe_in = 1'b0; iCmd_in = '0; iAck_in = 1'b0; iCard_status = '0;

    // 1: reset
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    chk("rst_idle", 64'(oIdle_out), 64'd1);
    chk("rst_ack", 64'(oAck_out), 64'd0);
    chk("rst_strobe", 64'(oStrobe_out), 64'd0);
    chk("rst_illegal", 64'(oIllegal_cmd), 64'd0);
    chk("rst_response", 64'(oResponse), 64'd0);

    // 2: CMD17, latency RESP_DELAY+2 = 6
    iCard_status = 32'h0000_0900;
    sendCmd(6'd17, 32'h0000_1000);
    chk("c17_index", 64'(oCmd_index), 64'd17);
    chk("c17_arg", 64'(oCmd_argument), 64'h1000);
    waitStrobe(lat);
    chk("c17_latency", 64'(lat), 64'd6);
    chk("c17_response", 64'(oResponse), 64'h11_0000_0900);
    finishResp();

    // 3: illegal CMD60, then two CMD13s
    iCard_status = 32'h0;
    sendCmd(6'd60, 32'h0);
    watchNoResp(10, ill, stb, idleAt);
    chk("c60_illegal_pulse", 64'(ill), 64'd1);
    chk("c60_no_strobe", 64'(stb), 64'd0);
    sendCmd(6'd13, 32'h0);
    waitStrobe(lat);
    chk("c13a_response", 64'(oResponse), 64'h0D_0040_0000);
    finishResp();
    sendCmd(6'd13, 32'h0);
    waitStrobe(lat);
    chk("c13b_response", 64'(oResponse), 64'h0D_0000_0000);
    finishResp();

    // 4: illegal, then GO_IDLE clears the flag
    sendCmd(6'd60, 32'h0);
    watchNoResp(5, ill, stb, idleAt);
    sendCmd(6'd0, 32'h0);
    watchNoResp(10, ill, stb, idleAt);
    chk("c0_no_strobe", 64'(stb), 64'd0);
    chk("c0_idle_in_3", 64'(idleAt >= 1 && idleAt <= 3), 64'd1);
    sendCmd(6'd13, 32'h0);
    waitStrobe(lat);
    chk("c0_c13_response", 64'(oResponse), 64'h0D_0000_0000);
    finishResp();

    // 5: stray strobe in WAIT, then long SEND hold
    iCard_status = 32'h1234_5678;
    sendCmd(6'd13, 32'hAAAA_0001);
    @(negedge clk);
    @(negedge clk);
    iStrobe_in = 1'b1;
    iCmd_in    = {6'd5, 32'h5555_5555};
    bad = 0;
    repeat (2) begin @(negedge clk); if (oAck_out) bad++; end
    iStrobe_in = 1'b0;
    chk("stray_no_ack", 64'(bad), 64'd0);
    chk("stray_index_kept", 64'(oCmd_index), 64'd13);
    waitStrobe(lat);
    chk("hold_strobe_seen", 64'(oStrobe_out), 64'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (oStrobe_out !== 1'b1 || oResponse !== 38'h0D_1234_5678) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    finishResp();

    // 7: ack already high when SEND is entered -> one-cycle strobe
    iCard_status = 32'h0000_0001;
    sendCmd(6'd7, 32'h0);
    iAck_in = 1'b1;
    stb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (oStrobe_out) stb++;
    end
    chk("early_ack_strobe_len", 64'(stb), 64'd1);
    chk("early_ack_response", 64'(oResponse), 64'h07_0000_0001);
    chk("early_ack_release_busy", 64'(oIdle_out), 64'd0);
    iAck_in = 1'b0;
    @(negedge clk);
    chk("early_ack_idle", 64'(oIdle_out), 64'd1);

    // 6: reset mid-WAIT with a pending illegal flag
    iCard_status = 32'h0;
    sendCmd(6'd60, 32'h0);
    watchNoResp(4, ill, stb, idleAt);
    sendCmd(6'd17, 32'h0000_0042);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("mid_rst_idle", 64'(oIdle_out), 64'd1);
    chk("mid_rst_response", 64'(oResponse), 64'd0);
    chk("mid_rst_index", 64'(oCmd_index), 64'd0);
    chk("mid_rst_arg", 64'(oCmd_argument), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (oStrobe_out || oAck_out) bad++;
    end
    chk("post_rst_quiet", 64'(bad), 64'd0);
    sendCmd(6'd13, 32'h0);
    waitStrobe(lat);
    chk("post_rst_sticky_clear", 64'(oResponse), 64'h0D_0000_0000);
    finishResp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
